// File: rtl/mw_pipe_reg_skid.sv
// Pipeline register with valid/ready handshake, optional 2-entry skid buffer,
// synchronous flush and optional control gating on bubbles.
module mw_pipe_reg_skid #(
  parameter int CTRL_W     = 3,
  parameter int DATA_W     = 68,
  parameter int SKID       = 1,
  parameter int CLEAR_CTRL = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  logic              main_valid;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic              in_fire;
  logic              out_fire;

  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign out_fire  = main_valid & out_ready;
  assign in_fire   = in_valid & in_ready;

  // Gating keeps a drained (stale) main entry from asserting RegWrite/PCSrc.
  generate
    if (CLEAR_CTRL != 0) begin : g_clear
      assign out_ctrl = main_ctrl & {CTRL_W{main_valid}};
    end else begin : g_raw
      assign out_ctrl = main_ctrl;
    end
  endgenerate

  generate
    if (SKID != 0) begin : g_skid
      logic              skid_valid;
      logic [CTRL_W-1:0] skid_ctrl;
      logic [DATA_W-1:0] skid_data;

      // skid_valid implies main_valid, so this encodes 0/1/2 directly.
      assign in_ready  = ~skid_valid;
      assign occupancy = {skid_valid, main_valid & ~skid_valid};

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          main_valid <= 1'b0;
          main_ctrl  <= '0;
          main_data  <= '0;
          skid_valid <= 1'b0;
          skid_ctrl  <= '0;
          skid_data  <= '0;
        end else if (flush) begin
          main_valid <= 1'b0;
          main_ctrl  <= '0;
          skid_valid <= 1'b0;
          skid_ctrl  <= '0;
        end else if (skid_valid) begin
          if (out_fire) begin
            main_ctrl  <= skid_ctrl;
            main_data  <= skid_data;
            skid_valid <= 1'b0;
          end
        end else if (main_valid) begin
          if (in_fire && out_fire) begin
            main_ctrl <= in_ctrl;
            main_data <= in_data;
          end else if (in_fire) begin
            skid_ctrl  <= in_ctrl;
            skid_data  <= in_data;
            skid_valid <= 1'b1;
          end else if (out_fire) begin
            main_valid <= 1'b0;
          end
        end else if (in_fire) begin
          main_ctrl  <= in_ctrl;
          main_data  <= in_data;
          main_valid <= 1'b1;
        end
      end
    end else begin : g_single
      assign in_ready  = out_ready | ~main_valid;
      assign occupancy = {1'b0, main_valid};

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          main_valid <= 1'b0;
          main_ctrl  <= '0;
          main_data  <= '0;
        end else if (flush) begin
          main_valid <= 1'b0;
          main_ctrl  <= '0;
        end else if (in_fire) begin
          main_ctrl  <= in_ctrl;
          main_data  <= in_data;
          main_valid <= 1'b1;
        end else if (out_fire) begin
          main_valid <= 1'b0;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_mw_pipe_reg_skid.sv
// Checks a SKID=1 and a SKID=0 instance against queue models of held beats.
module tb_mw_pipe_reg_skid;
  localparam int CW = 3;
  localparam int DW = 68;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } beat_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // Instance A: SKID=1
  logic          in_valid = 1'b0, out_ready = 1'b0, flush = 1'b0;
  logic [CW-1:0] in_ctrl = '0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready, out_valid;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;

  // Instance B: SKID=0
  logic          b_in_valid = 1'b0, b_out_ready = 1'b0, b_flush = 1'b0;
  logic [CW-1:0] b_in_ctrl = '0;
  logic [DW-1:0] b_in_data = '0;
  logic          b_in_ready, b_out_valid;
  logic [CW-1:0] b_out_ctrl;
  logic [DW-1:0] b_out_data;
  logic [1:0]    b_occupancy;

  mw_pipe_reg_skid #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CLEAR_CTRL(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data), .occupancy(occupancy)
  );

  mw_pipe_reg_skid #(.CTRL_W(CW), .DATA_W(DW), .SKID(0), .CLEAR_CTRL(1)) dut_b (
    .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_ctrl(b_in_ctrl), .in_data(b_in_data), .flush(b_flush), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_ctrl(b_out_ctrl), .out_data(b_out_data), .occupancy(b_occupancy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each instance is a FIFO of held beats; capacity 2 or 1.
  beat_t qa[$];
  beat_t qb[$];
  beat_t a_seen[$];
  beat_t b_seen[$];
  beat_t ma, mb;
  bit    a_in_fire, a_out_fire, b_in_fire, b_out_fire;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      qa.delete();
      qb.delete();
    end else begin
      a_in_fire  = in_valid && (qa.size() < 2);
      a_out_fire = (qa.size() > 0) && out_ready;
      b_in_fire  = b_in_valid && (b_out_ready || qb.size() == 0);
      b_out_fire = (qb.size() > 0) && b_out_ready;
      ma.c = in_ctrl;   ma.d = in_data;
      mb.c = b_in_ctrl; mb.d = b_in_data;
      if (flush) qa.delete();
      else begin
        if (a_out_fire) void'(qa.pop_front());
        if (a_in_fire) qa.push_back(ma);
      end
      if (b_flush) qb.delete();
      else begin
        if (b_out_fire) void'(qb.pop_front());
        if (b_in_fire) qb.push_back(mb);
      end
    end
  end

  // Per-cycle compare against the model, plus a log of beats leaving.
  always @(negedge clk) begin
    if (!reset) begin
      check("a_valid", out_valid, qa.size() > 0);
      check("a_occupancy", occupancy, qa.size());
      check("a_in_ready", in_ready, qa.size() < 2);
      check("a_ctrl", out_ctrl, (qa.size() > 0) ? qa[0].c : '0);
      if (qa.size() > 0) check("a_data", out_data, qa[0].d);
      check("b_valid", b_out_valid, qb.size() > 0);
      check("b_occupancy", b_occupancy, qb.size());
      check("b_in_ready", b_in_ready, b_out_ready || qb.size() == 0);
      check("b_ctrl", b_out_ctrl, (qb.size() > 0) ? qb[0].c : '0);
      if (qb.size() > 0) check("b_data", b_out_data, qb[0].d);
      if (out_valid && out_ready) a_seen.push_back(beat_t'({out_ctrl, out_data}));
      if (b_out_valid && b_out_ready) b_seen.push_back(beat_t'({b_out_ctrl, b_out_data}));
    end
  end

  task automatic send_a(input logic [CW-1:0] c, input logic [DW-1:0] d);
    int n;
    @(posedge clk); #1;
    in_valid = 1'b1; in_ctrl = c; in_data = d;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("send_a_accept_timeout", n < 20, 1'b1);
  endtask

  task automatic idle_a();
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
  endtask

  initial begin
    logic [95:0] r;
    logic [DW-1:0] bdat;
    logic          acc;
    int            n;

    #1 reset = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_occupancy", occupancy, 2'd0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_b_in_ready", b_in_ready, 1'b1);
    @(posedge clk); #1 reset = 1'b0;

    // Streaming: back-to-back beats, 1-cycle latency, never stalls.
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_ctrl = 3'b110; in_data = DW'(8'h10 + i);
      @(negedge clk);
      check("stream_in_ready", in_ready, 1'b1);
      if (i > 0) begin
        check("stream_data", out_data, 128'(8'h10 + i - 1));
        check("stream_ctrl", out_ctrl, 3'b110);
      end
    end
    idle_a();
    repeat (3) @(posedge clk);

    // Backpressure: A on output, B in skid, C held upstream.
    a_seen.delete();
    @(posedge clk); #1 out_ready = 1'b0;
    send_a(3'b101, 68'h1);
    send_a(3'b101, 68'h2);
    @(posedge clk); #1 in_data = 68'h3;
    @(negedge clk);
    check("bp_occupancy", occupancy, 2'd2);
    check("bp_in_ready", in_ready, 1'b0);
    check("bp_out_data", out_data, 128'h1);
    repeat (2) @(negedge clk);
    @(posedge clk); #1 out_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    idle_a();
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("bp_drain_count", a_seen.size(), 3);
    for (int k = 0; k < 3 && k < a_seen.size(); k++)
      check("bp_order", a_seen[k].d, 128'(k + 1));

    // Flush in FULL with a beat presented, then flush in BUSY with a beat firing.
    a_seen.delete();
    @(posedge clk); #1 out_ready = 1'b0;
    send_a(3'b111, 68'h21);
    send_a(3'b111, 68'h22);
    @(posedge clk); #1 in_data = 68'h55; flush = 1'b1;
    idle_a();
    @(negedge clk);
    check("flush_occupancy", occupancy, 2'd0);
    check("flush_out_valid", out_valid, 1'b0);
    check("flush_out_ctrl", out_ctrl, 3'b000);
    send_a(3'b011, 68'h23);
    @(posedge clk); #1 in_data = 68'h56; flush = 1'b1;
    @(negedge clk);
    check("flush_busy_in_ready", in_ready, 1'b1);
    idle_a();
    @(posedge clk); #1 out_ready = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("flush_nothing_emerged", a_seen.size(), 0);

    // Control gating after a drained beat.
    send_a(3'b111, 68'h77);
    idle_a();
    @(negedge clk);
    check("gate_ctrl_live", out_ctrl, 3'b111);
    @(negedge clk);
    check("gate_valid_low", out_valid, 1'b0);
    check("gate_ctrl_zero", out_ctrl, 3'b000);

    // Async reset mid-cycle with occupancy 2.
    @(posedge clk); #1 out_ready = 1'b0;
    send_a(3'b110, 68'h31);
    send_a(3'b110, 68'h32);
    idle_a();
    @(negedge clk);
    check("areset_pre_occupancy", occupancy, 2'd2);
    @(posedge clk); #2 reset = 1'b1;
    #1;
    check("areset_out_valid", out_valid, 1'b0);
    check("areset_out_ctrl", out_ctrl, 3'b000);
    check("areset_out_data", out_data, 128'h0);
    check("areset_occupancy", occupancy, 2'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("areset_in_ready", in_ready, 1'b1);

    // SKID=0: continuous in_valid with out_ready toggling.
    b_seen.delete();
    bdat = 68'h40;
    acc = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (acc) bdat = bdat + 1'b1;
      b_in_valid = 1'b1; b_in_ctrl = 3'b010; b_in_data = bdat;
      b_out_ready = (i % 3) != 1;
      @(negedge clk);
      acc = b_in_ready;
      check("b_occ_max", b_occupancy <= 2'd1, 1'b1);
    end
    @(posedge clk); #1 b_in_valid = 1'b0; b_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("b_seen_nonempty", b_seen.size() > 4, 1'b1);
    for (int k = 0; k < b_seen.size(); k++)
      check("b_order", b_seen[k].d, 128'(8'h40 + k));

    // Randomized traffic on both instances.
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      r = {$urandom(), $urandom(), $urandom()};
      in_valid  = $urandom_range(0, 1) == 1;
      in_ctrl   = CW'($urandom());
      in_data   = r[DW-1:0];
      out_ready = $urandom_range(0, 2) != 0;
      flush     = $urandom_range(0, 19) == 0;
      r = {$urandom(), $urandom(), $urandom()};
      b_in_valid  = $urandom_range(0, 1) == 1;
      b_in_ctrl   = CW'($urandom());
      b_in_data   = r[DW-1:0];
      b_out_ready = $urandom_range(0, 1) == 1;
      b_flush     = $urandom_range(0, 19) == 0;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0; b_in_valid = 1'b0; b_flush = 1'b0;
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
